instr_prefetch_queue: RTL and testbench

INSTR_PREFETCH_QUEUE -- requirements
Module: instr_prefetch_queue

---
 rtl/instr_prefetch_queue.sv | 160 ++++++++++++++++
 tb/tb_instr_prefetch_queue.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_prefetch_queue.sv
// -----------------------------------------------------------------------------
// instr_prefetch_queue
//
// Instruction prefetcher feeding a small FIFO of {pc, instr} pairs to decode.
// Issues at most one memory read at a time. When JAL_PREDECODE is set, a JAL
// returned by memory steers the next fetch to its target immediately.
// A redirect from execute flushes the FIFO and restarts fetch. A response
// still in flight at that moment is marked for discard, and the next rvalid
// is then dropped.
//
// Handshakes:
//   imem: imem_req/imem_addr are held until imem_gnt. The request is
//         withdrawn only while redirect is high. Exactly one imem_rvalid
//         answers each granted request. An rvalid with nothing outstanding is
//         ignored.
//   if  : the head entry transfers on if_valid & if_ready. if_instr and if_pc
//         are stable while if_valid is high and if_ready is low.
//
// Ports:
//   clk, reset               clock; asynchronous active-low reset
//   redirect, redirect_pc    flush request and new fetch address
//   imem_req, imem_addr      read request and its address
//   imem_gnt                 request accepted this cycle
//   imem_rvalid, imem_rdata  read response
//   if_valid, if_ready       head handshake toward decode
//   if_instr, if_pc          head entry
//   q_count                  occupied FIFO entries
// -----------------------------------------------------------------------------
module instr_prefetch_queue #(
    parameter int              XLEN          = 32,
    parameter int              DEPTH         = 4,
    parameter logic [XLEN-1:0] RESET_PC      = '0,
    parameter bit              JAL_PREDECODE = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     redirect,
    input  logic [XLEN-1:0]          redirect_pc,
    output logic                     imem_req,
    output logic [XLEN-1:0]          imem_addr,
    input  logic                     imem_gnt,
    input  logic                     imem_rvalid,
    input  logic [31:0]              imem_rdata,
    output logic                     if_valid,
    input  logic                     if_ready,
    output logic [31:0]              if_instr,
    output logic [XLEN-1:0]          if_pc,
    output logic [$clog2(DEPTH):0]   q_count
);

    localparam int              AW         = $clog2(DEPTH);
    localparam int              CW         = AW + 1;
    localparam logic [CW-1:0]   FULL_COUNT = CW'(DEPTH);
    localparam logic [6:0]      OPC_JAL    = 7'b1101111;

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] req_pc;
    logic            outstanding;
    logic            discard;

    logic [XLEN-1:0] pc_mem    [DEPTH];
    logic [31:0]     instr_mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;

    logic            req_ok;
    logic            granted;
    logic            rsp;
    logic            push;
    logic            pop;
    logic            is_jal;
    logic [20:0]     jal_imm;
    logic [XLEN-1:0] jal_target;
    logic [XLEN-1:0] next_fetch_pc;

    // req_ok ignores redirect on purpose: a grant that lands in a redirect
    // cycle still starts a transfer on the memory side, so it must be tracked
    // as outstanding and then discarded.
    assign req_ok   = reset & ~outstanding & (count != FULL_COUNT) & ~discard;
    assign granted  = req_ok & imem_gnt;
    assign rsp      = imem_rvalid & outstanding;
    assign push     = rsp & ~discard & ~redirect;
    assign pop      = (count != '0) & if_ready & ~redirect;

    assign imem_req  = req_ok & ~redirect;
    assign imem_addr = fetch_pc;

    assign jal_imm       = {imem_rdata[31], imem_rdata[19:12], imem_rdata[20],
                            imem_rdata[30:21], 1'b0};
    assign jal_target    = req_pc + {{(XLEN-21){jal_imm[20]}}, jal_imm};
    assign is_jal        = JAL_PREDECODE && (imem_rdata[6:0] == OPC_JAL);
    assign next_fetch_pc = is_jal ? jal_target : (req_pc + XLEN'(4));

    assign if_valid = (count != '0);
    assign if_instr = instr_mem[rd_ptr];
    assign if_pc    = pc_mem[rd_ptr];
    assign q_count  = count;

    // Fetch control and FIFO bookkeeping
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc    <= RESET_PC;
            req_pc      <= RESET_PC;
            outstanding <= 1'b0;
            discard     <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
        end else if (redirect) begin
            fetch_pc <= redirect_pc;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            if (granted) begin
                outstanding <= 1'b1;
                discard     <= 1'b1;
                req_pc      <= fetch_pc;
            end else if (rsp) begin
                // The in-flight response lands in this cycle and is dropped.
                outstanding <= 1'b0;
                discard     <= 1'b0;
            end else if (outstanding) begin
                discard <= 1'b1;
            end
        end else begin
            if (granted) begin
                outstanding <= 1'b1;
                req_pc      <= fetch_pc;
            end
            if (rsp) begin
                outstanding <= 1'b0;
                discard     <= 1'b0;
                if (!discard) begin
                    fetch_pc <= next_fetch_pc;
                end
            end
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage. A valid flag is not needed because count gates if_valid.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]    <= req_pc;
            instr_mem[wr_ptr] <= imem_rdata;
        end
    end

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// -----------------------------------------------------------------------------
// tb_instr_prefetch_queue
//
// Randomized bench for instr_prefetch_queue. A behavioural model keeps the
// expected FIFO contents in a queue and tracks fetch state from the rules of
// the prefetcher. A simple memory responder answers each grant after 1-4
// cycles and sometimes sends stray rvalids. Reset pulses are placed
// mid-traffic, and decode stalls are long enough to fill the FIFO.
// -----------------------------------------------------------------------------
module tb_instr_prefetch_queue;

    localparam int          XLEN     = 32;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0040;
    localparam int          NCYC     = 3000;

    logic              clk;
    logic              reset;
    logic              redirect;
    logic [XLEN-1:0]   redirect_pc;
    logic              imem_req;
    logic [XLEN-1:0]   imem_addr;
    logic              imem_gnt;
    logic              imem_rvalid;
    logic [31:0]       imem_rdata;
    logic              if_valid;
    logic              if_ready;
    logic [31:0]       if_instr;
    logic [XLEN-1:0]   if_pc;
    logic [$clog2(DEPTH):0] q_count;

    instr_prefetch_queue #(
        .XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC), .JAL_PREDECODE(1'b1)
    ) dut (
        .clk(clk), .reset(reset),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .if_valid(if_valid), .if_ready(if_ready),
        .if_instr(if_instr), .if_pc(if_pc), .q_count(q_count)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // scoreboard: expected FIFO entries {pc, instr}, head at index 0
    logic [XLEN+31:0] exp_q[$];
    logic [XLEN-1:0]  m_fetch;
    logic [XLEN-1:0]  m_req_pc;
    bit               m_out;
    bit               m_disc;

    // memory responder
    int               mem_lat;
    logic [31:0]      mem_data;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    endtask

    // Next fetch address after a returned word: JAL target or sequential.
    function automatic logic [31:0] model_next_pc(input logic [31:0] pc, input logic [31:0] w);
        longint imm;
        if (w[6:0] == 7'h6F) begin
            imm = (longint'(w[30:21]) * 2) + (longint'(w[20]) * 2048) + (longint'(w[19:12]) * 4096);
            if (w[31]) imm = imm - 1048576;
            return 32'(longint'(pc) + imm);
        end
        return pc + 32'd4;
    endfunction

    function automatic logic [31:0] gen_instr();
        int r;
        logic [31:0] w;
        r = $urandom_range(0, 9);
        w = $urandom;
        case (r)
            0:       return 32'h0080006F;
            1:       return 32'hFF9FF06F;
            2:       return {w[31:7], 7'h6F};
            default: return w;
        endcase
    endfunction

    task automatic model_reset();
        exp_q.delete();
        m_fetch  = RESET_PC;
        m_req_pc = RESET_PC;
        m_out    = 1'b0;
        m_disc   = 1'b0;
    endtask

    initial begin
        bit req_ok, exp_req, grant_evt, rsp, do_pop;
        int since_rst;
        logic [XLEN+31:0] head;

        reset       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        if_ready    = 1'b0;
        mem_lat     = 0;
        mem_data    = '0;
        since_rst   = 0;
        model_reset();

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge clk);
            // driver
            reset = !(cyc < 2 || (cyc % 500) == 250);
            if (!reset) since_rst = 0;
            else since_rst++;

            redirect    = (since_rst > 1) && ($urandom_range(0, 15) == 0);
            redirect_pc = ($urandom_range(0, 3) == 0) ? 32'h100 : ($urandom & 32'hFFFF_FFFC);
            if (((cyc / 150) % 4) == 2) if_ready = ($urandom_range(0, 19) == 0);
            else if_ready = ($urandom_range(0, 9) < 6);
            // Hold grants off just after reset so a late response can show up.
            imem_gnt = (since_rst > 3) && ($urandom_range(0, 9) < 7);

            if (mem_lat == 1) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_data;
            end else if (mem_lat == 0 && !m_out && $urandom_range(0, 19) == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = $urandom;
            end else begin
                imem_rvalid = 1'b0;
                imem_rdata  = $urandom;
            end

            if (!reset) model_reset();
            #1;

            // expected outputs
            req_ok  = reset && !m_out && (exp_q.size() < DEPTH) && !m_disc;
            exp_req = req_ok && !redirect;
            check_eq("imem_req", 64'(imem_req), 64'(exp_req));
            check_eq("imem_addr", 64'(imem_addr), 64'(m_fetch));
            check_eq("if_valid", 64'(if_valid), 64'(exp_q.size() != 0));
            check_eq("q_count", 64'(q_count), 64'(exp_q.size()));
            if (exp_q.size() != 0) begin
                head = exp_q[0];
                check_eq("if_pc", 64'(if_pc), 64'(head[XLEN+31:32]));
                check_eq("if_instr", 64'(if_instr), 64'(head[31:0]));
            end

            // memory responder advance
            grant_evt = req_ok && imem_gnt;
            if (mem_lat > 0) mem_lat--;
            if (grant_evt) begin
                mem_lat  = $urandom_range(1, 4);
                mem_data = gen_instr();
            end

            // model advance
            if (reset) begin
                rsp = m_out && imem_rvalid;
                if (redirect) begin
                    exp_q.delete();
                    if (grant_evt) begin
                        m_out    = 1'b1;
                        m_disc   = 1'b1;
                        m_req_pc = m_fetch;
                    end else if (rsp) begin
                        m_out  = 1'b0;
                        m_disc = 1'b0;
                    end else if (m_out) begin
                        m_disc = 1'b1;
                    end
                    m_fetch = redirect_pc;
                end else begin
                    do_pop = (exp_q.size() != 0) && if_ready;
                    if (do_pop) void'(exp_q.pop_front());
                    if (rsp) begin
                        if (!m_disc) begin
                            exp_q.push_back({m_req_pc, imem_rdata});
                            m_fetch = model_next_pc(m_req_pc, imem_rdata);
                        end
                        m_out  = 1'b0;
                        m_disc = 1'b0;
                    end else if (grant_evt) begin
                        m_out    = 1'b1;
                        m_req_pc = m_fetch;
                    end
                end
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
